// File: rtl/mig_app_responder_if.sv
// ---------------------------------------------------------------------------
// mig_app_responder_if
// Groups the MIG user (app_*) signals between a controller (master) and the
// responder standing in for the MIG core (slave). Clock and reset are carried
// as plain ports on the modules, not through this interface.
//
// Signals:
//   app_addr[28:0]        command address (word index taken from bits [..:3])
//   app_cmd[2:0]          3'b000 write, 3'b001 read, others illegal
//   app_en / app_rdy      command handshake
//   app_wdf_data[127:0]   write-data beat
//   app_wdf_mask[15:0]    byte mask, 1 = byte not written
//   app_wdf_wren/_end     write-data valid / last-beat marker
//   app_wdf_rdy           write-data accept
//   app_rd_data[127:0]    read data
//   app_rd_data_valid/_end read data valid (one cycle per read)
//   init_calib_complete   interface usable
//   err                   sticky protocol-error flag
// ---------------------------------------------------------------------------
interface mig_app_if;
  logic [28:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         err;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end, init_calib_complete, err
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end, init_calib_complete, err
  );
endinterface

// File: rtl/mig_app_responder.sv
// ---------------------------------------------------------------------------
// mig_app_responder
// Synthesizable stand-in for the Xilinx MIG core plus DDR3 device. Accepts
// read/write commands and write-data beats on the MIG user interface, stores
// 128-bit words in an internal RAM with byte masking, and returns read data a
// fixed READ_LATENCY cycles after each read executes.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset (RAM contents are kept)
//   app   mig_app_if.slave - full app_* command/write/read bundle
//
// Optional feature: define MIG_RESP_STALL_EN to add pseudo-random
// back-pressure on app_rdy / app_wdf_rdy driven by a 16-bit LFSR.
// ---------------------------------------------------------------------------
module mig_app_responder #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int CMD_DEPTH     = 4,
  parameter int WDF_DEPTH     = 4,
  parameter int READ_LATENCY  = 8,
  parameter int CALIB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  mig_app_if.slave app
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int WPW = $clog2(WDF_DEPTH);
  localparam int CCW = $clog2(CALIB_CYCLES) + 1;

  typedef enum logic {S_CALIB, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CCW-1:0]   calib_cnt_q, calib_cnt_d;
  logic             run;

  // Command FIFO
  logic [2:0]               cmd_op_q  [CMD_DEPTH];
  logic [MEM_ADDR_BITS-1:0] cmd_idx_q [CMD_DEPTH];
  logic [CPW-1:0]           cmd_wr_q, cmd_rd_q;
  logic [CPW:0]             cmd_cnt_q;
  logic                     cmd_full, cmd_push, cmd_pop;

  // Write-data FIFO
  logic [127:0]             wdf_data_q [WDF_DEPTH];
  logic [15:0]              wdf_mask_q [WDF_DEPTH];
  logic [WPW-1:0]           wdf_wr_q, wdf_rd_q;
  logic [WPW:0]             wdf_cnt_q;
  logic                     wdf_full, wdf_push, wdf_pop;

  // Execution
  logic [2:0]               head_op;
  logic [MEM_ADDR_BITS-1:0] head_idx;
  logic [127:0]             head_data;
  logic [15:0]              head_mask;
  logic                     head_vld, wdf_vld;
  logic                     exec_rd, exec_wr, exec_bad;

  // RAM and read delay line
  logic [127:0]             mem_q [2**MEM_ADDR_BITS];
  logic [127:0]             rd_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0]  rd_vld_q;

  logic                     err_q;
  logic                     wdf_proto_bad;
  logic                     stall_cmd, stall_wdf;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^{app.app_addr[28:MEM_ADDR_BITS+3], app.app_addr[2:0]};

  // ---- Calibration / run FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CALIB;
      calib_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      calib_cnt_q <= calib_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    case (state_q)
      S_CALIB: begin
        if (calib_cnt_q == CCW'(CALIB_CYCLES - 1)) state_d = S_RUN;
        else                                      calib_cnt_d = calib_cnt_q + CCW'(1);
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_CALIB;
    endcase
  end

  assign run = (state_q == S_RUN);

  // ---- Optional random back-pressure ----
`ifdef MIG_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; only advances while running.
  always_ff @(posedge clk) begin
    if (rst)      lfsr_q <= 16'hACE1;
    else if (run) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall_cmd = lfsr_q[0];
  assign stall_wdf = lfsr_q[1];
`else
  assign stall_cmd = 1'b0;
  assign stall_wdf = 1'b0;
`endif

  // Readiness uses registered full flags only, so a pop never frees a slot
  // for a push in the same cycle.
  assign cmd_full        = (cmd_cnt_q == (CPW+1)'(CMD_DEPTH));
  assign wdf_full        = (wdf_cnt_q == (WPW+1)'(WDF_DEPTH));
  assign app.app_rdy     = run && !cmd_full && !stall_cmd;
  assign app.app_wdf_rdy = run && !wdf_full && !stall_wdf;
  assign cmd_push        = app.app_en && app.app_rdy;
  assign wdf_push        = app.app_wdf_wren && app.app_wdf_rdy;

  // ---- Execution engine: one head command per cycle, strictly in order ----
  assign head_vld  = (cmd_cnt_q != '0);
  assign wdf_vld   = (wdf_cnt_q != '0);
  assign head_op   = cmd_op_q[cmd_rd_q];
  assign head_idx  = cmd_idx_q[cmd_rd_q];
  assign head_data = wdf_data_q[wdf_rd_q];
  assign head_mask = wdf_mask_q[wdf_rd_q];

  // A write at the head without its data stalls everything behind it.
  assign exec_rd  = head_vld && (head_op == 3'b001);
  assign exec_wr  = head_vld && (head_op == 3'b000) && wdf_vld;
  assign exec_bad = head_vld && (head_op != 3'b000) && (head_op != 3'b001);
  assign cmd_pop  = exec_rd || exec_wr || exec_bad;
  assign wdf_pop  = exec_wr;

  assign wdf_proto_bad = run && ((wdf_push && !app.app_wdf_end) ||
                                 (app.app_wdf_end && !app.app_wdf_wren));

  // ---- FIFO storage (data, not reset) ----
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_op_q[cmd_wr_q]  <= app.app_cmd;
      cmd_idx_q[cmd_wr_q] <= app.app_addr[MEM_ADDR_BITS+2:3];
    end
    if (wdf_push) begin
      wdf_data_q[wdf_wr_q] <= app.app_wdf_data;
      wdf_mask_q[wdf_wr_q] <= app.app_wdf_mask;
    end
  end

  // ---- FIFO pointers, counts, error flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      wdf_wr_q  <= '0;
      wdf_rd_q  <= '0;
      wdf_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (cmd_push) cmd_wr_q <= cmd_wr_q + CPW'(1);
      if (cmd_pop)  cmd_rd_q <= cmd_rd_q + CPW'(1);
      cmd_cnt_q <= cmd_cnt_q + (CPW+1)'(cmd_push) - (CPW+1)'(cmd_pop);
      if (wdf_push) wdf_wr_q <= wdf_wr_q + WPW'(1);
      if (wdf_pop)  wdf_rd_q <= wdf_rd_q + WPW'(1);
      wdf_cnt_q <= wdf_cnt_q + (WPW+1)'(wdf_push) - (WPW+1)'(wdf_pop);
      if (exec_bad || wdf_proto_bad) err_q <= 1'b1;
    end
  end

  // ---- RAM write (kept across reset; no write on a reset edge) ----
  always_ff @(posedge clk) begin
    if (!rst && exec_wr) begin
      for (int b = 0; b < 16; b++) begin
        if (!head_mask[b]) mem_q[head_idx][8*b +: 8] <= head_data[8*b +: 8];
      end
    end
  end

  // ---- Read delay line: stage 0 is the RAM read register ----
  always_ff @(posedge clk) begin
    if (exec_rd) rd_data_q[0] <= mem_q[head_idx];
    for (int i = 1; i < READ_LATENCY; i++) rd_data_q[i] <= rd_data_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q[0] <= exec_rd;
      for (int i = 1; i < READ_LATENCY; i++) rd_vld_q[i] <= rd_vld_q[i-1];
    end
  end

  // Data is zeroed outside valid cycles so the bus reads 0 after reset.
  assign app.app_rd_data         = rd_vld_q[READ_LATENCY-1] ? rd_data_q[READ_LATENCY-1] : '0;
  assign app.app_rd_data_valid   = rd_vld_q[READ_LATENCY-1];
  assign app.app_rd_data_end     = rd_vld_q[READ_LATENCY-1];
  assign app.init_calib_complete = run;
  assign app.err                 = err_q;

endmodule

// File: doc/mig_app_responder.md
# mig_app_responder

Synthesizable responder for the MIG user (app_*) interface: it sits at the far end of the command/write-data/read-data handshake that `ddr3_controller_fsm` drives, standing in for the Xilinx MIG core and DDR3 device. It accepts read and write commands, stores 128-bit words in an internal RAM with byte masking, and returns read data after a fixed latency. It is used in simulation and in FPGA builds without external DDR3, and lets the controller FSM be verified in isolation.

## Interface
- MEM_ADDR_BITS, 10: log2 of the number of 128-bit words in the internal RAM.
- CMD_DEPTH, 4: command FIFO entries (power of 2, ≥2).
- WDF_DEPTH, 4: write-data FIFO entries (power of 2, ≥2).
- READ_LATENCY, 8: cycles from read execution to `app_rd_data_valid` (≥1).
- CALIB_CYCLES, 16: cycles after reset before `init_calib_complete` asserts (≥1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- app_addr  in  29  command address; word index = app_addr[MEM_ADDR_BITS+2:3]; bits [2:0] and upper bits ignored.
- app_cmd  in  3  3'b000 write, 3'b001 read; other values illegal.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept; transfer when app_en && app_rdy.
- app_wdf_data  in  128  write data beat.
- app_wdf_mask  in  16  byte mask; bit i = 1 → byte i NOT written.
- app_wdf_wren  in  1  write-data valid.
- app_wdf_end  in  1  last beat marker; must equal app_wdf_wren (one beat per burst).
- app_wdf_rdy  out  1  write-data accept; transfer when app_wdf_wren && app_wdf_rdy.
- app_rd_data  out  128  read data.
- app_rd_data_valid  out  1  read data valid, one cycle per read.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  interface usable.
- err  out  1  sticky protocol-error flag.

## Operation
- Top FSM: CALIB → RUN. CALIB: counter runs CALIB_CYCLES cycles; app_rdy, app_wdf_rdy, init_calib_complete held 0; app_en/app_wdf_wren ignored. RUN: init_calib_complete = 1 until reset.
- app_rdy = RUN && !cmd_full; app_wdf_rdy = RUN && !wdf_full. Both derived from registered full flags only; no same-cycle pop pass-through.
- Accepted command pushes {cmd, word index}; accepted beat pushes {data, mask}. Data may arrive before, with, or after its command; pairing is strictly in order.
- Execution engine, at most one command per cycle, in FIFO order:
  - head READ: pop, read RAM, enter READ_LATENCY delay line.
  - head WRITE: only if wdf non-empty; pop both, write unmasked bytes. If wdf empty, head stalls (younger reads also stall: ordering preserved).
  - head illegal cmd: pop, discard, set err.
- app_wdf_wren accepted with app_wdf_end = 0, or app_wdf_end = 1 without wren: set err; beat still accepted as normal.
- RAM contents are not reset; unwritten words read as X in simulation.

## Timing
- Reset values: app_rdy 0, app_wdf_rdy 0, app_rd_data 0, app_rd_data_valid 0, app_rd_data_end 0, init_calib_complete 0, err 0.
- init_calib_complete rises exactly CALIB_CYCLES cycles after the first cycle with rst low; app_rdy/app_wdf_rdy rise the same cycle.
- Command accepted in cycle t executes no earlier than t+1. Read executed in cycle e: app_rd_data_valid in cycle e+READ_LATENCY; back-to-back reads give back-to-back valids.
- Write executed in cycle e is visible to a read executed in e+1 or later.
- Full FIFO with simultaneous pop: ready stays 0 that cycle, rises next cycle.
- rst asserted mid-operation: FIFOs, delay line, counters cleared next edge; in-flight reads dropped (no valid); RAM preserved; FSM returns to CALIB.

## Configuration
- MIG_RESP_STALL_EN defined: 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11), advanced every RUN cycle; LFSR[0] = 1 forces app_rdy = 0 and LFSR[1] = 1 forces app_wdf_rdy = 0 that cycle, exercising initiator back-pressure. Ordering and data unchanged.
- Undefined: no random stalls; readiness depends only on FSM state and FIFO full flags.

## Test plan
- Reset, then idle: init_calib_complete, app_rdy, app_wdf_rdy all 0 for 16 cycles, 1 from cycle 16.
- Write addr 29'h40 data 128'h0123…CDEF mask 0, then read 29'h40 -> one valid, READ_LATENCY cycles after execution, data 128'h0123…CDEF.
- Write all-ones to word 5, then write zeros with mask 16'hFF00, read -> 128'h…FFFF_FFFF_FFFF_FFFF_0000… pattern: upper 8 bytes 1s, lower 8 bytes 0s.
- Issue 5 write commands with no data -> app_rdy drops after 4 accepted; supply 4 beats -> writes complete, app_rdy reasserts; a queued read behind returns correct data.
- app_cmd 3'b111 accepted -> no read valid, err = 1 and stays 1 until rst.
- rst pulse with 3 reads in flight -> no app_rd_data_valid afterwards; recalibrate; read of previously written word returns stored data.
